// File: rtl/a2d_intf_pkg.sv
// Shared types and constants for the A2D responder and its SPI engine.
// Build option: A2D_RES_INV_EN (see a2d_intf.sv).
package a2d_intf_pkg;

   typedef enum logic [1:0] {IDLE, TX_CMD, GAP, TX_RD} a2d_state_t;

   localparam logic [1:0] ADC_CMD_PAD     = 2'b00;
   localparam int         XFER_BITS       = 16;
   localparam int         SCLK_DIV_W_DFLT = 5;
   // SS_n low time of one transaction: front porch plus one SCLK period per bit
   localparam int         XFER_CLKS       = 2**(SCLK_DIV_W_DFLT-2) + XFER_BITS * 2**SCLK_DIV_W_DFLT;

   function automatic logic [15:0] adc_cmd(input logic [2:0] ch);
      return {ADC_CMD_PAD, ch, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// Requester-facing conversion handshake of the A2D responder.
interface a2d_intf_if;

   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;

   modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
   modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);

endinterface

// File: rtl/a2d_intf_spi_mstr16.sv
// One 16-bit SPI transaction, CPOL=1/CPHA=1, SCLK = clk / 2**SCLK_DIV_W.
// done pulses combinationally with rd_data valid on the edge SS_n returns high.
module a2d_intf_spi_mstr16
   import a2d_intf_pkg::*;
#(
   parameter int SCLK_DIV_W = SCLK_DIV_W_DFLT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] cmd,
   input  logic        MISO,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI
);

   localparam int W = SCLK_DIV_W;
   localparam logic [W-1:0] DIV_LOAD = W'(2**W - 2**(W-2) - 1);
   localparam logic [W-1:0] DIV_SMPL = W'(2**(W-1) - 1);
   localparam logic [W-1:0] DIV_WRAP = '1;

   logic          ss_n_q, ss_n_d;
   logic          sclk_q, sclk_d;
   logic          start_q, start_d;
   logic [W-1:0]  div_q, div_d;
   logic [15:0]   shft_q, shft_d;
   logic          smpl_q, smpl_d;
   logic [4:0]    wrap_cnt_q, wrap_cnt_d;

   logic          active;
   logic          wrap;
   logic          last;

   always_comb begin
      ss_n_d     = ss_n_q;
      start_d    = start_q;
      div_d      = div_q;
      shft_d     = shft_q;
      smpl_d     = smpl_q;
      wrap_cnt_d = wrap_cnt_q;
      done       = 1'b0;

      active = start_q | ~ss_n_q;
      wrap   = ~ss_n_q & (div_q == DIV_WRAP);
      last   = wrap & (wrap_cnt_q == 5'(XFER_BITS));

      if (wrt && ss_n_q && !start_q) begin
         // load one clk ahead of SS_n falling so the front porch is 2**(W-2) clk
         shft_d     = cmd;
         div_d      = DIV_LOAD;
         start_d    = 1'b1;
         wrap_cnt_d = '0;
      end else if (active) begin
         start_d = 1'b0;
         ss_n_d  = 1'b0;
         div_d   = div_q + 1'b1;
         if (!ss_n_q && div_q == DIV_SMPL)
            smpl_d = MISO;
         // the first SCLK fall has no preceding rise, so it shifts nothing
         if (wrap) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
            if (wrap_cnt_q != 5'd0)
               shft_d = {shft_q[14:0], smpl_q};
         end
         if (last) begin
            ss_n_d = 1'b1;
            done   = 1'b1;
         end
      end

      sclk_d = (active && !last) ? div_d[W-1] : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_n_q     <= 1'b1;
         sclk_q     <= 1'b1;
         start_q    <= 1'b0;
         div_q      <= '0;
         shft_q     <= '0;
         smpl_q     <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         ss_n_q     <= ss_n_d;
         sclk_q     <= sclk_d;
         start_q    <= start_d;
         div_q      <= div_d;
         shft_q     <= shft_d;
         smpl_q     <= smpl_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign rd_data = {shft_q[14:0], smpl_q};
   assign SS_n    = ss_n_q;
   assign SCLK    = sclk_q;
   assign MOSI    = shft_q[15];

endmodule

// File: rtl/a2d_intf.sv
// A2D responder: command transaction, SS_n gap, readback transaction, then result.
// Build option: A2D_RES_INV_EN inverts the returned 12-bit result.
module a2d_intf
   import a2d_intf_pkg::*;
#(
   parameter int SCLK_DIV_W = SCLK_DIV_W_DFLT,
   parameter int GAP_CYC    = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   a2d_intf_if.slave    bus,
   output logic         SS_n,
   output logic         SCLK,
   output logic         MOSI,
   input  logic         MISO
);

   localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
   // counter runs GAP_CYC-2 .. 0; the load and start cycles make up the rest
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 2);

   a2d_state_t    state_q, state_d;
   logic [2:0]    chnnl_q, chnnl_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [11:0]   res_q, res_d;
   logic          cmplt_q, cmplt_d;

   logic          wrt;
   logic [15:0]   cmd;
   logic          done;
   logic [15:0]   rd_data;
   logic [3:0]    rd_hi_unused;

   function automatic logic [11:0] res_fmt(input logic [11:0] raw);
`ifdef A2D_RES_INV_EN
      return ~raw;
`else
      return raw;
`endif
   endfunction

   a2d_intf_spi_mstr16 #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt     (wrt),
      .cmd     (cmd),
      .MISO    (MISO),
      .done    (done),
      .rd_data (rd_data),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI)
   );

   assign rd_hi_unused = rd_data[15:12];

   always_comb begin
      state_d = state_q;
      chnnl_d = chnnl_q;
      gap_d   = gap_q;
      res_d   = res_q;
      cmplt_d = cmplt_q;
      wrt     = 1'b0;
      cmd     = adc_cmd(chnnl_q);

      case (state_q)
         IDLE: begin
            if (bus.strt_cnv) begin
               wrt     = 1'b1;
               cmd     = adc_cmd(bus.chnnl);
               chnnl_d = bus.chnnl;
               cmplt_d = 1'b0;
               state_d = TX_CMD;
            end
         end
         TX_CMD: begin
            if (done) begin
               gap_d   = GAP_LOAD;
               state_d = GAP;
            end
         end
         GAP: begin
            // readback re-requests the same channel; the ADC answers the first request
            if (gap_q == '0) begin
               wrt     = 1'b1;
               state_d = TX_RD;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         TX_RD: begin
            if (done) begin
               res_d   = res_fmt(rd_data[11:0]);
               cmplt_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         chnnl_q <= '0;
         gap_q   <= '0;
         res_q   <= '0;
         cmplt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         chnnl_q <= chnnl_d;
         gap_q   <= gap_d;
         res_q   <= res_d;
         cmplt_q <= cmplt_d;
      end
   end

   assign bus.cnv_cmplt = cmplt_q;
   assign bus.res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf: behavioural SPI ADC model plus per-conversion
// handshake, result and SPI timing checks against fixed expected numbers.
module tb_a2d_intf;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic SS_n, SCLK, MOSI;
   logic MISO = 1'b0;

   a2d_intf_if bus();

   a2d_intf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .SS_n  (SS_n),
      .SCLK  (SCLK),
      .MOSI  (MOSI),
      .MISO  (MISO)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] exp_res(input logic [11:0] v);
`ifdef A2D_RES_INV_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   // ---------------- behavioural ADC: returns the previously requested channel
   logic [11:0] adc_val [8];
   logic [15:0] tx_word = 16'h0000;
   logic [15:0] rx_word = 16'h0000;
   int          rise_cnt = 0;
   int          bit_idx = 15;
   logic        m_prev_ss = 1'b1;
   logic        m_prev_sck = 1'b1;
   logic [15:0] cmd_log[$];

   always @(SS_n or SCLK) begin
      if (m_prev_ss === 1'b1 && SS_n === 1'b0) begin
         rise_cnt = 0;
         bit_idx  = 15;
         rx_word  = 16'h0000;
      end else if (m_prev_ss === 1'b0 && SS_n === 1'b1) begin
         if (rise_cnt == 16) begin
            cmd_log.push_back(rx_word);
            tx_word = {4'($urandom), adc_val[rx_word[13:11]]};
         end
      end else if (SS_n === 1'b0 && m_prev_sck === 1'b0 && SCLK === 1'b1) begin
         rx_word = {rx_word[14:0], MOSI};
         rise_cnt++;
      end else if (SS_n === 1'b0 && m_prev_sck === 1'b1 && SCLK === 1'b0) begin
         if (bit_idx >= 0) begin
            MISO = tx_word[bit_idx];
            bit_idx--;
         end
      end
      m_prev_ss  = SS_n;
      m_prev_sck = SCLK;
   end

   // One conversion on channel ch, optionally pulsing strt_cnv with poke_ch at
   // relative edge poke_at. Called and returns at a falling clk edge.
   task automatic run_conv(input logic [2:0] ch, input int poke_at, input logic [2:0] poke_ch);
      int rel, e0, lat, nwin, nfall, last_fall, period_bad, stray, hold_bad;
      int ss_fall[2], ss_rise[2], first_fall[2], falls[2];
      logic prev_ss, prev_sck, fin;
      logic [11:0] old_res;
      logic [15:0] exp_cmd;
      logic [15:0] c0, c1;
      for (int i = 0; i < 2; i++) begin
         ss_fall[i] = -5000; ss_rise[i] = -5000; first_fall[i] = -9000; falls[i] = -1;
      end
      nwin = 0; nfall = 0; last_fall = 0; period_bad = 0; stray = 0; hold_bad = 0;
      lat = -1; fin = 1'b0;
      old_res = bus.res;
      exp_cmd = 16'(ch) << 11;
      cmd_log.delete();

      bus.strt_cnv = 1'b1;
      bus.chnnl    = ch;
      @(negedge clk);
      e0 = cyc;
      bus.strt_cnv = 1'b0;
      bus.chnnl    = 3'($urandom);
      chk("cmplt_clr", {31'd0, bus.cnv_cmplt}, 32'd0);
      prev_ss  = SS_n;
      prev_sck = SCLK;

      for (int k = 0; k < 1500 && !fin; k++) begin
         @(negedge clk);
         rel = cyc - e0;
         if (poke_at > 0 && rel == poke_at - 1) begin
            bus.strt_cnv = 1'b1;
            bus.chnnl    = poke_ch;
         end else if (poke_at > 0 && rel == poke_at) begin
            bus.strt_cnv = 1'b0;
         end
         if (prev_ss && !SS_n) begin
            if (nwin < 2) ss_fall[nwin] = rel;
            nfall = 0;
         end
         if (!prev_ss && SS_n) begin
            if (nwin < 2) begin
               ss_rise[nwin] = rel;
               falls[nwin]   = nfall;
            end
            nwin++;
         end
         if (prev_sck && !SCLK) begin
            if (!SS_n) begin
               if (nfall == 0) begin
                  if (nwin < 2) first_fall[nwin] = rel;
               end else if (rel - last_fall != 32) begin
                  period_bad++;
               end
               last_fall = rel;
               nfall++;
            end else begin
               stray++;
            end
         end
         prev_ss  = SS_n;
         prev_sck = SCLK;
         if (bus.cnv_cmplt) begin
            fin = 1'b1;
            lat = rel;
         end else if (bus.res !== old_res) begin
            hold_bad++;
         end
      end

      c0 = (cmd_log.size() > 0) ? cmd_log[0] : 16'hFFFF;
      c1 = (cmd_log.size() > 1) ? cmd_log[1] : 16'hFFFF;
      chk("latency", lat, 1073);
      chk("ss_windows", nwin, 2);
      chk("ss_fall_edge", ss_fall[0], 1);
      chk("ss_low_cmd", ss_rise[0] - ss_fall[0], 520);
      chk("ss_low_rd", ss_rise[1] - ss_fall[1], 520);
      chk("ss_gap", ss_fall[1] - ss_rise[0], 32);
      chk("porch_cmd", first_fall[0] - ss_fall[0], 8);
      chk("porch_rd", first_fall[1] - ss_fall[1], 8);
      chk("falls_cmd", falls[0], 16);
      chk("falls_rd", falls[1], 16);
      chk("sclk_period", period_bad, 0);
      chk("sclk_idle", stray, 0);
      chk("res_hold", hold_bad, 0);
      chk("res", {20'd0, bus.res}, {20'd0, exp_res(adc_val[ch])});
      chk("cmd_cnt", cmd_log.size(), 2);
      chk("mosi_cmd", {16'd0, c0}, {16'd0, exp_cmd});
      chk("mosi_rd", {16'd0, c1}, {16'd0, exp_cmd});
   endtask

   initial begin
      logic [2:0] ch;
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      bus.strt_cnv = 1'b0;
      bus.chnnl    = 3'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ss", {31'd0, SS_n}, 32'd1);
      chk("rst_sclk", {31'd0, SCLK}, 32'd1);
      chk("rst_mosi", {31'd0, MOSI}, 32'd0);
      chk("rst_cmplt", {31'd0, bus.cnv_cmplt}, 32'd0);
      chk("rst_res", {20'd0, bus.res}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // reference conversion: channel 3 reads 12'hA5C
      adc_val[3] = 12'hA5C;
      run_conv(3'd3, 0, 3'd0);
      repeat (5) @(negedge clk);

      // request while busy is ignored
      run_conv(3'd1, 300, 3'd5);

      // back-to-back: strt_cnv one clk after cnv_cmplt
      run_conv(3'd7, 0, 3'd0);
      repeat (4) @(negedge clk);

      // all channels, random ADC contents
      for (int c = 0; c < 8; c++) begin
         adc_val[c] = 12'($urandom);
         run_conv(3'(c), 0, 3'd0);
         repeat ($urandom_range(1, 6)) @(negedge clk);
      end

      // asynchronous reset in the middle of the command transaction
      bus.strt_cnv = 1'b1;
      bus.chnnl    = 3'd2;
      @(negedge clk);
      bus.strt_cnv = 1'b0;
      repeat (199) @(negedge clk);
      chk("mid_ss_low", {31'd0, SS_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_ss", {31'd0, SS_n}, 32'd1);
      chk("arst_sclk", {31'd0, SCLK}, 32'd1);
      chk("arst_mosi", {31'd0, MOSI}, 32'd0);
      chk("arst_cmplt", {31'd0, bus.cnv_cmplt}, 32'd0);
      chk("arst_res", {20'd0, bus.res}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      ch = 3'($urandom);
      adc_val[ch] = 12'($urandom);
      run_conv(ch, 0, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
